// File: rtl/stitch_collector_pkg.sv
// Shared constants and helpers for the stitched-pipeline result collector.
package stitch_collector_pkg;

  localparam int MAX_LATENCY = 8;
  localparam int MAX_DEPTH   = 16;

  // Bits needed to hold the values 0..n inclusive (an occupancy count).
  function automatic int clog2_p1(int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/stitch_pipeline_collector_if.sv
// Issue and result handshake bundle between a fixed-latency pipeline, the collector and downstream.
interface stitch_pipeline_collector_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] pipe_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // master: the surrounding environment (issuer, pipeline, consumer)
  modport master (
    output issue_valid, pipe_out, out_ready,
    input  issue_ready, out_valid, out_data
  );

  // slave: the collector itself
  modport slave (
    input  issue_valid, pipe_out, out_ready,
    output issue_ready, out_valid, out_data
  );
endinterface

// File: rtl/stitch_collector_fifo.sv
// Circular-buffer FIFO with registered occupancy; head is a mux of registered memory (no bypass).
module stitch_collector_fifo
  import stitch_collector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [clog2_p1(DEPTH)-1:0]   count
);

  localparam int CNT_W = clog2_p1(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is dropped unless the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage has no reset; out_valid gates it, and leaving it out keeps it plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stitch_pipeline_collector.sv
// Tracks real results through a non-stalling pipeline with a valid shift register, buffers them and
// issues credits so no result is ever lost. Optional sticky overflow check: STITCH_COLLECTOR_OVERFLOW_CHECK_EN.
module stitch_pipeline_collector
  import stitch_collector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  stitch_pipeline_collector_if.slave   bus,
  output logic [clog2_p1(DEPTH)-1:0]   count,
  output logic                         err_overflow
);

  localparam int INF_W = clog2_p1(LATENCY);

  logic [LATENCY-1:0] vld;
  logic [INF_W-1:0]   inflight;
  logic               credit_ok;
  logic               accept;
  logic               arrival;
  logic               pop;

  // Credits come from registered state only; a same-cycle pop frees a credit one cycle later.
  assign credit_ok       = (32'(inflight) + 32'(count)) < DEPTH;
  assign bus.issue_ready = credit_ok;
  assign accept          = bus.issue_valid && credit_ok;
  assign arrival         = vld[LATENCY-1];
  assign bus.out_valid   = (count != '0);
  assign pop             = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      inflight <= '0;
    end else begin
      vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      case ({accept, arrival})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  stitch_collector_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (arrival),
    .push_data (bus.pipe_out),
    .pop       (pop),
    .head      (bus.out_data),
    .count     (count)
  );

`ifdef STITCH_COLLECTOR_OVERFLOW_CHECK_EN
  logic err_q;

  // The FIFO drops the offending result itself; here we only latch the event until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (arrival && (count == $bits(count)'(DEPTH)) && !pop) begin
      err_q <= 1'b1;
    end
  end

  assign err_overflow = err_q;
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stitch_pipeline_collector.sv
// Scoreboard bench: a model of the 42+b pipeline feeds the collector; accepted issues queue expected
// results and a negedge monitor compares every popped output against that queue.
module tb_stitch_pipeline_collector;

  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  count;
  logic        err_overflow;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] stg [LAT];

  int passed;
  int total;
  int accepted;
  bit suppress;
  logic [31:0] exp_q[$];

  stitch_pipeline_collector_if #(.DATA_W(DATA_W)) bus ();

  stitch_pipeline_collector #(
    .DATA_W  (DATA_W),
    .LATENCY (LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .count        (count),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline model: registers every cycle, no valid of its own.
  always @(posedge clk) begin
    stg[0] <= op_a + op_b;
    for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
  end
  assign bus.pipe_out = stg[LAT-1];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit iv, logic [31:0] a, logic [31:0] b, bit ordy);
    bus.issue_valid = iv;
    bus.out_ready   = ordy;
    op_a = a;
    op_b = b;
    if (iv && bus.issue_ready) begin
      accepted++;
      if (!suppress) exp_q.push_back(a + b);
    end
  endtask

  task automatic drain(string name, int budget);
    drive(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check({name, "_drain_done"}, exp_q.size(), 0);
    tick();
    check({name, "_empty_valid"}, bus.out_valid, 1'b0);
    check({name, "_empty_count"}, count, 0);
  endtask

  // Monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", bus.out_valid, 1'b0);
      else check("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    int bad;
    logic [31:0] held;
    passed = 0; total = 0; accepted = 0; suppress = 0;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_issue_ready", bus.issue_ready, 1'b1);
    check("rst_count", count, 0);
    check("rst_err", err_overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single issue: 42+64 appears after the third edge for exactly one cycle.
    drive(1'b1, 42, 64, 1'b1);
    tick();
    drive(1'b0, 0, 0, 1'b1);
    check("single_e1_valid", bus.out_valid, 1'b0);
    tick();
    check("single_e2_valid", bus.out_valid, 1'b0);
    tick();
    check("single_e3_valid", bus.out_valid, 1'b1);
    check("single_e3_data", bus.out_data, 32'h0000_006A);
    tick();
    check("single_e4_valid", bus.out_valid, 1'b0);

    // Streaming with distinct operands; credits must never run out.
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.issue_ready) drops++;
      drive(1'b1, 42, 64 + i, 1'b1);
      tick();
    end
    check("stream_ready_drops", drops, 0);
    check("stream_accepted", accepted, 21);
    drain("stream", 20);

    // Back-pressure: exactly DEPTH results accepted, head held.
    accepted = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 42, 64 + i, 1'b0);
      tick();
      if (bus.out_valid && bus.out_data !== 32'h6A) bad++;
    end
    check("bp_accepted", accepted, DEPTH);
    check("bp_count", count, DEPTH);
    check("bp_issue_ready", bus.issue_ready, 1'b0);
    check("bp_head", bus.out_data, 32'h6A);
    check("bp_head_unstable", bad, 0);

    // One pop from full: credit returns next cycle, refills LATENCY edges after the accept.
    drive(1'b1, 42, 200, 1'b1);
    tick();
    check("pop1_count", count, 3);
    check("pop1_ready", bus.issue_ready, 1'b1);
    drive(1'b1, 42, 201, 1'b0);
    tick();
    check("refill_ready", bus.issue_ready, 1'b0);
    check("refill_a_count", count, 3);
    drive(1'b1, 42, 202, 1'b0);
    tick();
    check("refill_b_count", count, 3);
    tick();
    check("refill_c_count", count, DEPTH);
    drain("refill", 20);

    // Reset mid-flight with two buffered and two in flight.
    drive(1'b1, 42, 300, 1'b0); tick();
    drive(1'b1, 42, 301, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b0);
    repeat (2) tick();
    check("prerst_count", count, 2);
    drive(1'b1, 42, 302, 1'b0); tick();
    drive(1'b1, 42, 303, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b1);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_count", count, 0);
    check("midrst_issue_ready", bus.issue_ready, 1'b1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) bad++;
    end
    check("postrst_no_valid", bad, 0);
    drive(1'b1, 42, 400, 1'b1);
    tick();
    drain("postrst", 10);

`ifdef STITCH_COLLECTOR_OVERFLOW_CHECK_EN
    // Overflow: bypass credits with the FIFO full.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 42, 500 + i, 1'b0);
      tick();
    end
    check("ovf_prefill_count", count, DEPTH);
    suppress = 1;
    force dut.credit_ok = 1'b1;
    drive(1'b1, 42, 600, 1'b0); tick();
    drive(1'b1, 42, 601, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) tick();
    release dut.credit_ok;
    suppress = 0;
    check("ovf_err", err_overflow, 1'b1);
    check("ovf_count", count, DEPTH);
    check("ovf_head", bus.out_data, 32'd542);
    drain("ovf", 20);
    check("ovf_err_sticky", err_overflow, 1'b1);
`else
    check("no_ovf_err", err_overflow, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
